// File: rtl/matrix_collector_pkg.sv
// Shared constants and types for the systolic-array edge blocks (feeder and collector).
package matrix_collector_pkg;

   localparam int unsigned N         = 4;
   localparam int unsigned NUM_BEATS = 2 * N - 1;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned BEAT_W    = 3;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [BEAT_W-1:0] beat_t;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } collector_state_t;

endpackage

// File: rtl/matrix_collector_if.sv
// Lane inputs, handshake and reassembled-matrix outputs of the collector.
interface matrix_collector_if;
   import matrix_collector_pkg::*;

   logic  start;
   logic  in_valid;
   logic  ack;
   data_t q1, q2, q3, q4;
   data_t c11, c12, c13, c14;
   data_t c21, c22, c23, c24;
   data_t c31, c32, c33, c34;
   data_t c41, c42, c43, c44;
   logic  busy;
   logic  done;
   logic  skew_err;

   modport master (
      output start, in_valid, ack, q1, q2, q3, q4,
      input  c11, c12, c13, c14, c21, c22, c23, c24,
             c31, c32, c33, c34, c41, c42, c43, c44,
             busy, done, skew_err
   );

   modport slave (
      input  start, in_valid, ack, q1, q2, q3, q4,
      output c11, c12, c13, c14, c21, c22, c23, c24,
             c31, c32, c33, c34, c41, c42, c43, c44,
             busy, done, skew_err
   );

endinterface

// File: rtl/matrix_collector_lane.sv
// One column of the collected matrix: lane J feeds row N-beat+J, other slots must be zero.
module matrix_collector_lane
   import matrix_collector_pkg::*;
#(
   parameter int unsigned J = 1
)
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  cap_en,
   input  beat_t beat,
   input  data_t q,
   output data_t col [N],
   output logic  viol_c
);

   localparam int unsigned IDX_W = $clog2(N);

   int               row_c;
   logic             hit_c;
   logic [IDX_W-1:0] idx_c;

   // Row addressed by this lane at the current beat, and zero-slot violation.
   always_comb begin
      row_c  = int'(N) + int'(J) - int'(beat);
      hit_c  = (row_c >= 1) && (row_c <= int'(N));
      idx_c  = IDX_W'(row_c - 1);
      viol_c = cap_en && !hit_c && (q != '0);
   end

   // Column registers: cleared on an accepted start, written on in-range beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(N); r++) col[r] <= '0;
      end else if (clr) begin
         for (int r = 0; r < int'(N); r++) col[r] <= '0;
      end else if (cap_en && hit_c) begin
         col[idx_c] <= q;
      end
   end

endmodule

// File: rtl/matrix_collector.sv
// Reassembles diagonally skewed systolic-array output into a registered 4x4 matrix.
module matrix_collector
   import matrix_collector_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   matrix_collector_if.slave bus
);

   localparam beat_t LAST_BEAT = beat_t'(NUM_BEATS);

   collector_state_t state;
   beat_t            beat;
   logic             busy_q;
   logic             done_q;
   logic             skew_q;
   logic             start_acc_c;
   logic             cap_en_c;
   logic [N-1:0]     viol_c;
   data_t            col1 [N];
   data_t            col2 [N];
   data_t            col3 [N];
   data_t            col4 [N];

   // A start is honoured from IDLE, or from DONE only together with ack.
   assign start_acc_c = bus.start && ((state == IDLE) || ((state == DONE) && bus.ack));
   assign cap_en_c    = (state == COLLECT) && bus.in_valid;

   // Handshake FSM with beat counter and sticky skew flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         beat   <= beat_t'(1);
         busy_q <= 1'b0;
         done_q <= 1'b0;
         skew_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_acc_c) begin
                  state  <= COLLECT;
                  beat   <= beat_t'(1);
                  busy_q <= 1'b1;
                  skew_q <= 1'b0;
               end
            end
            COLLECT: begin
               if (cap_en_c) begin
                  if (|viol_c) skew_q <= 1'b1;
                  if (beat == LAST_BEAT) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     beat <= beat + beat_t'(1);
                  end
               end
            end
            DONE: begin
               if (bus.ack) begin
                  done_q <= 1'b0;
                  if (start_acc_c) begin
                     state  <= COLLECT;
                     beat   <= beat_t'(1);
                     busy_q <= 1'b1;
                     skew_q <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   matrix_collector_lane #(.J(1)) u_lane1 (
      .clk(clk), .rst_n(rst_n), .clr(start_acc_c), .cap_en(cap_en_c),
      .beat(beat), .q(bus.q1), .col(col1), .viol_c(viol_c[0])
   );
   matrix_collector_lane #(.J(2)) u_lane2 (
      .clk(clk), .rst_n(rst_n), .clr(start_acc_c), .cap_en(cap_en_c),
      .beat(beat), .q(bus.q2), .col(col2), .viol_c(viol_c[1])
   );
   matrix_collector_lane #(.J(3)) u_lane3 (
      .clk(clk), .rst_n(rst_n), .clr(start_acc_c), .cap_en(cap_en_c),
      .beat(beat), .q(bus.q3), .col(col3), .viol_c(viol_c[2])
   );
   matrix_collector_lane #(.J(4)) u_lane4 (
      .clk(clk), .rst_n(rst_n), .clr(start_acc_c), .cap_en(cap_en_c),
      .beat(beat), .q(bus.q4), .col(col4), .viol_c(viol_c[3])
   );

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.skew_err = skew_q;

   assign bus.c11 = col1[0];
   assign bus.c21 = col1[1];
   assign bus.c31 = col1[2];
   assign bus.c41 = col1[3];
   assign bus.c12 = col2[0];
   assign bus.c22 = col2[1];
   assign bus.c32 = col2[2];
   assign bus.c42 = col2[3];
   assign bus.c13 = col3[0];
   assign bus.c23 = col3[1];
   assign bus.c33 = col3[2];
   assign bus.c43 = col3[3];
   assign bus.c14 = col4[0];
   assign bus.c24 = col4[1];
   assign bus.c34 = col4[2];
   assign bus.c44 = col4[3];

endmodule

// File: doc/matrix_collector.md
Name: matrix_collector

Overview:
- Receiving end of the skewed systolic-array data path.
- Accepts four 32-bit lanes per cycle, arriving diagonal by diagonal over 2N-1 = 7 beats, and reassembles them into a registered 4x4 matrix c11..c44.
- Sits at the output edge of the systolic array, mirroring the matrix feeder at its input edge.
- Handshakes completion with its consumer and flags skew violations.

Parameters:
- DATA_W, 32, width of each lane and matrix element
- N, 4, matrix dimension; fixed at 4 in this revision (ports are unrolled)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse that arms a new collection
- in_valid  input  1  q1..q4 carry a beat this cycle
- q1, q2, q3, q4  input  DATA_W  lane j data, j = 1..4
- ack  input  1  consumer has taken the matrix
- c11..c44  output  DATA_W each (16 ports)  reassembled matrix element row i, column j
- busy  output  1  collection in progress
- done  output  1  matrix complete and stable
- skew_err  output  1  sticky flag: a lane carried nonzero data in a slot that must be zero

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; beat=1
  - all cij=0; busy=0; done=0; skew_err=0
- States:
  - IDLE -> COLLECT on start=1. Same edge: clear all cij and skew_err, set beat=1, busy=1.
  - COLLECT:
    - On each edge with in_valid=1, capture beat b and then increment b.
    - in_valid=0 stalls; b and cij hold.
    - start is ignored.
    - On the edge that captures b=7: go to DONE, busy=0, done=1.
  - DONE:
    - cij held stable; done=1.
    - ack=1 -> IDLE, done=0.
    - ack=1 and start=1 on the same edge -> COLLECT directly: cij cleared, beat=1, busy=1, done=0.
    - start without ack is ignored.
- Lane mapping at beat b (1..7): lane j carries row i = 4 - b + j.
  - If 1 <= i <= 4, register cij <= qj.
  - Otherwise the slot must be zero. A nonzero qj sets skew_err=1 (sticky until the next accepted start); no cij is written.
  - Equivalent listing:
    - b1: q1->c41
    - b2: q1->c31, q2->c42
    - b3: q1->c21, q2->c32, q3->c43
    - b4: q1->c11, q2->c22, q3->c33, q4->c44
    - b5: q2->c12, q3->c23, q4->c34
    - b6: q3->c13, q4->c24
    - b7: q4->c14
- Timing:
  - Data beats start the cycle after start. A beat presented on the start cycle itself is ignored.
  - Latency from the last accepted beat (b=7) to done=1 is one clock.
- in_valid in IDLE or DONE is ignored: no writes, no skew_err.
- ack outside DONE is ignored.
- Reset mid-collection aborts immediately to the reset values; a partial matrix is never presented.
- Beat counter is 3 bits and never wraps past 7 inside COLLECT.
- No arithmetic on data; all registers are DATA_W wide, no truncation.

Decomposition:
- Shared package (also used by the feeder):
  - constants N=4, NUM_BEATS=2*N-1, DATA_W=32
  - beat counter width (3)
  - typedef collector_state_t {IDLE, COLLECT, DONE}
- One natural sub-module: collector_lane.
  - One instance per lane j; holds column j's four registers.
  - Inputs: beat, capture enable, qj. Outputs: the four column elements and a per-lane zero-slot violation.
  - The top level owns the FSM, the beat counter, the OR of the violations into skew_err, and the handshake.

Test Plan:
- Basic capture:
  - Stimulus: start, then 7 consecutive valid beats from the listing, with cij = 0x000000ij (e.g. beat 4: q1=0x11, q2=0x22, q3=0x33, q4=0x44) and zeros elsewhere.
  - Response: done=1 exactly one cycle after beat 7; c23=0x23, c41=0x41, c14=0x14; skew_err=0; busy low.
- Stalls:
  - Stimulus: same data with in_valid=0 inserted after beats 2 and 5.
  - Response: identical matrix; done asserts 9 cycles after the first beat.
- Skew error:
  - Stimulus: beat 1 with q2=0xDEAD (zero slot), rest as in basic capture.
  - Response: skew_err=1 and remains set through DONE; all cij still correct; the next start clears skew_err.
- Back-to-back:
  - Stimulus: in DONE, drive ack=1 and start=1 on the same cycle; collect a second matrix with cij = 0x100+ij.
  - Response: done drops, busy=1, cij clear to 0, then c11=0x111 at completion.
- Ignore and abort:
  - Stimulus: start during COLLECT, and in_valid during IDLE. Separately, assert rst_n=0 after beat 3.
  - Response: no effect from the stray start or in_valid. After the reset, all outputs are 0 and state is IDLE; done never pulses for the aborted matrix.
